// File: rtl/stream_rr_arbiter.sv
// Round-robin, packet-locking arbiter: NIN valid/ready/last streams share one registered output stage.
// The grant is held from the first beat until the owner's last beat is accepted.
module stream_rr_arbiter #(
  parameter int NIN          = 4,
  parameter int DW           = 8,
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NIN-1:0]    i_valid,
  output logic [NIN-1:0]    o_ready,
  input  logic [NIN*DW-1:0] i_data,
  input  logic [NIN-1:0]    i_last,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DW-1:0]     o_data,
  output logic              o_last,
  output logic [NIN-1:0]    o_grant,
  output logic              o_busy
);

  localparam int IW = (NIN > 1) ? $clog2(NIN) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   prio_q, prio_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [NIN-1:0]  grant_q, grant_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   data_q, data_d;
  logic            last_q, last_d;

  logic            out_free_s;
  logic            accept_s;
  logic [IW-1:0]   pick_s;
  logic            pick_ok_s;
  logic [IW-1:0]   idx_s;

  assign out_free_s = !valid_q || i_ready;
  assign accept_s   = (state_q == LOCKED) && i_valid[owner_q] && out_free_s;

  // Walk from farthest to nearest after prio_q so the nearest requester wins the last write.
  always_comb begin
    pick_s    = prio_q;
    pick_ok_s = 1'b0;
    idx_s     = '0;
    for (int i = NIN; i >= 1; i--) begin
      idx_s = IW'((int'(prio_q) + i) % NIN);
      if (i_valid[idx_s]) begin
        pick_s    = idx_s;
        pick_ok_s = 1'b1;
      end else begin
        pick_ok_s = pick_ok_s;
      end
    end
  end

  // Only the owner sees ready, and only when the output register can take a beat.
  always_comb begin
    if ((state_q == LOCKED) && out_free_s) begin
      o_ready = grant_q;
    end else begin
      o_ready = '0;
    end
  end

  // Next-state: arbitration in IDLE, beat transfer and release in LOCKED, output pop.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    grant_d = grant_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
      if (OPT_LOWPOWER) begin
        data_d = '0;
        last_d = 1'b0;
      end else begin
        data_d = data_q;
      end
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      IDLE: begin
        if (pick_ok_s) begin
          state_d = LOCKED;
          owner_d = pick_s;
          grant_d = NIN'(1'b1) << pick_s;
        end else begin
          grant_d = '0;
        end
      end
      LOCKED: begin
        if (accept_s) begin
          valid_d = 1'b1;
          data_d  = i_data[int'(owner_q)*DW +: DW];
          last_d  = i_last[owner_q];
          if (i_last[owner_q]) begin
            state_d = IDLE;
            grant_d = '0;
            prio_d  = owner_q;
          end else begin
            state_d = LOCKED;
          end
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and output registers; reset restores requester 0 as highest priority.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      prio_q  <= IW'(NIN - 1);
      owner_q <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;
  assign o_grant = grant_q;
  assign o_busy  = (state_q == LOCKED);

endmodule

// Requester-side protocol rules and arbiter one-hot invariants.
module stream_rr_arbiter_checker #(
  parameter int NIN = 4,
  parameter int DW  = 8
) (
  input logic              i_clk,
  input logic              i_reset_n,
  input logic [NIN-1:0]    i_valid,
  input logic [NIN-1:0]    o_ready,
  input logic [NIN*DW-1:0] i_data,
  input logic [NIN-1:0]    i_last,
  input logic [NIN-1:0]    o_grant
);

  for (genvar k = 0; k < NIN; k++) begin : g_req
    a_hold_stable: assert property (@(posedge i_clk) disable iff (!i_reset_n)
      (i_valid[k] && !o_ready[k]) |=>
        (i_valid[k] && $stable(i_data[k*DW +: DW]) && $stable(i_last[k])));
  end

  a_ready_onehot: assert property (@(posedge i_clk) disable iff (!i_reset_n) $onehot0(o_ready));
  a_grant_onehot: assert property (@(posedge i_clk) disable iff (!i_reset_n) $onehot0(o_grant));
  a_ready_owner:  assert property (@(posedge i_clk) disable iff (!i_reset_n) ((o_ready & ~o_grant) == '0));

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter with an output-beat scoreboard and a low-power twin instance.
module tb_stream_rr_arbiter;

  localparam int NIN = 4;
  localparam int DW  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NIN-1:0]    valid;
  logic [NIN*DW-1:0] data;
  logic [NIN-1:0]    last;
  logic              rdy;

  logic [NIN-1:0]    ready, ready_lp;
  logic              ovalid, ovalid_lp;
  logic [DW-1:0]     odata, odata_lp;
  logic              olast, olast_lp;
  logic [NIN-1:0]    grant, grant_lp;
  logic              busy, busy_lp;

  int nchecks = 0;
  int nerr    = 0;
  logic [8:0] expq[$];

  always #5 clk = ~clk;

  stream_rr_arbiter #(.NIN(NIN), .DW(DW), .OPT_LOWPOWER(1'b0)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .o_ready(ready), .i_data(data),
    .i_last(last), .o_valid(ovalid), .i_ready(rdy), .o_data(odata), .o_last(olast),
    .o_grant(grant), .o_busy(busy)
  );

  stream_rr_arbiter #(.NIN(NIN), .DW(DW), .OPT_LOWPOWER(1'b1)) dut_lp (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .o_ready(ready_lp), .i_data(data),
    .i_last(last), .o_valid(ovalid_lp), .i_ready(rdy), .o_data(odata_lp), .o_last(olast_lp),
    .o_grant(grant_lp), .o_busy(busy_lp)
  );

  stream_rr_arbiter_checker #(.NIN(NIN), .DW(DW)) u_chk (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .o_ready(ready), .i_data(data),
    .i_last(last), .o_grant(grant)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic v, input logic [7:0] d, input logic l);
    valid[k]          = v;
    data[k*DW +: DW]  = d;
    last[k]           = l;
  endtask

  // Sample point: pop the scoreboard on a downstream transfer and compare the twin instance.
  task automatic cb();
    logic [8:0] e;
    @(negedge clk);
    if (ovalid && rdy) begin
      chk("beat_expected", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("beat", 32'({olast, odata}), 32'(e));
      end
    end
    chk("lp_valid", 32'(ovalid_lp), 32'(ovalid));
    chk("lp_ready", 32'(ready_lp), 32'(ready));
    if (!ovalid_lp) chk("lp_zero", 32'({olast_lp, odata_lp}), 32'd0);
    else            chk("lp_data", 32'({olast_lp, odata_lp}), 32'({olast, odata}));
  endtask

  task automatic ce();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(ovalid), 32'd0);
    chk({tag, "_data"},  32'(odata),  32'd0);
    chk({tag, "_last"},  32'(olast),  32'd0);
    chk({tag, "_grant"}, 32'(grant),  32'd0);
    chk({tag, "_busy"},  32'(busy),   32'd0);
    chk({tag, "_ready"}, 32'(ready),  32'd0);
    chk({tag, "_lpgnt"}, 32'(grant_lp), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    valid = '0;
    data  = '0;
    last  = '0;
    rdy   = 1'b1;
    #12;
    chk_all_zero("reset");
    ce();
    rst_n = 1'b1;

    // Fairness: four requesters with continuous single-beat packets.
    for (int k = 0; k < NIN; k++) set_req(k, 1'b1, 8'(8'hA0 + k), 1'b1);
    for (int n = 0; n < 8; n++) begin
      cb(); chk("fair_idle", 32'(grant), 32'd0); ce();
      cb();
      chk("fair_grant", 32'(grant), 32'(4'b0001 << (n % NIN)));
      expq.push_back({1'b1, 8'(8'hA0 + (n % NIN))});
      ce();
      if (n >= NIN) valid[n % NIN] = 1'b0;
    end
    cb(); chk("fair_end", 32'(grant), 32'd0); ce();

    // Single requester 2, three-beat packet.
    set_req(2, 1'b1, 8'h11, 1'b0); expq.push_back({1'b0, 8'h11});
    cb(); chk("t1_c0_grant", 32'(grant), 32'd0); chk("t1_c0_ready", 32'(ready), 32'd0); ce();
    cb(); chk("t1_c1_grant", 32'(grant), 32'h4); chk("t1_c1_ready", 32'(ready), 32'h4);
    chk("t1_c1_busy", 32'(busy), 32'd1); ce();
    set_req(2, 1'b1, 8'h22, 1'b0); expq.push_back({1'b0, 8'h22});
    cb(); chk("t1_c2_valid", 32'(ovalid), 32'd1); chk("t1_c2_ready", 32'(ready), 32'h4); ce();
    set_req(2, 1'b1, 8'h33, 1'b1); expq.push_back({1'b1, 8'h33});
    cb(); chk("t1_c3_ready", 32'(ready), 32'h4); ce();
    set_req(2, 1'b0, 8'h00, 1'b0);
    cb(); chk("t1_c4_grant", 32'(grant), 32'd0); chk("t1_c4_busy", 32'(busy), 32'd0); ce();
    cb(); chk("t1_c5_grant", 32'(grant), 32'd0); chk("t1_c5_valid", 32'(ovalid), 32'd0); ce();

    // Backpressure on a two-beat packet from requester 1.
    set_req(1, 1'b1, 8'h51, 1'b0); expq.push_back({1'b0, 8'h51});
    cb(); ce();
    cb(); chk("bp_grant", 32'(grant), 32'h2); ce();
    set_req(1, 1'b1, 8'h52, 1'b1); expq.push_back({1'b1, 8'h52});
    rdy = 1'b0;
    for (int s = 0; s < 5; s++) begin
      cb();
      chk("bp_valid", 32'(ovalid), 32'd1);
      chk("bp_data",  32'(odata),  32'h51);
      chk("bp_ready", 32'(ready),  32'd0);
      ce();
    end
    rdy = 1'b1;
    cb(); chk("bp_resume_ready", 32'(ready), 32'h2); ce();
    set_req(1, 1'b0, 8'h00, 1'b0);
    cb(); chk("bp_last", 32'(olast), 32'd1); ce();
    cb(); ce();

    // Lock hold: owner 0 idles mid-packet while requester 3 waits.
    set_req(0, 1'b1, 8'h61, 1'b0); expq.push_back({1'b0, 8'h61});
    cb(); ce();
    cb(); chk("lk_grant0", 32'(grant), 32'h1); ce();
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(3, 1'b1, 8'h71, 1'b1);
    for (int s = 0; s < 10; s++) begin
      cb();
      chk("lk_hold_grant", 32'(grant), 32'h1);
      chk("lk_ready3", 32'(ready[3]), 32'd0);
      chk("lk_busy", 32'(busy), 32'd1);
      ce();
    end
    set_req(0, 1'b1, 8'h62, 1'b1); expq.push_back({1'b1, 8'h62});
    cb(); chk("lk_ready0", 32'(ready), 32'h1); ce();
    set_req(0, 1'b0, 8'h00, 1'b0);
    cb(); chk("lk_idle", 32'(grant), 32'd0); ce();
    expq.push_back({1'b1, 8'h71});
    cb(); chk("lk_grant3", 32'(grant), 32'h8); ce();
    set_req(3, 1'b0, 8'h00, 1'b0);
    cb(); ce();
    cb(); ce();

    // Reset mid-packet: move the pointer to 0, start a packet on 1, then reset.
    set_req(0, 1'b1, 8'h81, 1'b1); expq.push_back({1'b1, 8'h81});
    cb(); ce();
    cb(); chk("rs_pre_grant0", 32'(grant), 32'h1); ce();
    set_req(0, 1'b0, 8'h00, 1'b0);
    cb(); ce();
    set_req(1, 1'b1, 8'h91, 1'b0); expq.push_back({1'b0, 8'h91});
    cb(); ce();
    cb(); chk("rs_pre_grant1", 32'(grant), 32'h2); ce();
    rst_n = 1'b0;
    valid = '0;
    data  = '0;
    last  = '0;
    expq.delete();
    #1;
    chk_all_zero("midrst");
    cb(); ce();
    cb(); ce();
    rst_n = 1'b1;
    set_req(0, 1'b1, 8'hA1, 1'b1);
    set_req(2, 1'b1, 8'hA2, 1'b1);
    cb(); chk("rs_idle", 32'(grant), 32'd0); ce();
    expq.push_back({1'b1, 8'hA1});
    cb(); chk("rs_first_grant", 32'(grant), 32'h1); ce();
    set_req(0, 1'b0, 8'h00, 1'b0);
    cb(); chk("rs_gap", 32'(grant), 32'd0); ce();
    expq.push_back({1'b1, 8'hA2});
    cb(); chk("rs_second_grant", 32'(grant), 32'h4); ce();
    set_req(2, 1'b0, 8'h00, 1'b0);
    cb(); ce();
    cb(); ce();

    chk("queue_empty", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
